fetch_queue: RTL and testbench

- Parametrised successor of the single-cycle fetch stage.
- Decouples PC generation from instruction memory: one outstanding request at a time to a variable-latency instruction memory; returned instructions buffered in a DEPTH-entry prefetch FIFO.
- Decode consumes entries with a valid/stall handshake.
- Redirects (register jump beats immediate jump) flush the FIFO and squash any in-flight response.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 68 ++++++
 rtl/fetch_queue.sv | 144 ++++++++++++++
 tb/tb_fetch_queue.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared defaults and the prefetch entry type for the decoupled fetch queue.
package fetch_pkg;

  localparam int unsigned DefAddrWidth  = 16;
  localparam int unsigned DefInstrWidth = 16;
  localparam int unsigned DefInstrBytes = 2;
  localparam int unsigned DefResetPc    = 0;

  typedef struct packed {
    logic [DefInstrWidth-1:0] instr;
    logic [DefAddrWidth-1:0]  pcPlus;
  } fq_entry_t;

  // True when addr is not a multiple of bytes (bytes must be a power of two).
  function automatic logic isMisaligned(input logic [63:0] addr, input int unsigned bytes);
    return (addr & (64'(bytes) - 64'd1)) != 64'd0;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO with flush; power-of-two depth, pointers wrap naturally.
module fetch_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [Width-1:0]         pushData_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         popData_o,
  output logic [$clog2(Depth):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wrPtr_q, wrPtr_d;
  logic [PtrW-1:0]  rdPtr_q, rdPtr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             pushEff, popEff;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  // Popping frees a slot in the same cycle, so a full FIFO may still accept a push.
  assign popEff  = pop_i & ~empty_o;
  assign pushEff = push_i & (~full_o | popEff);

  assign popData_o = mem_q[rdPtr_q];

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (flush_i) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (pushEff) wrPtr_d = wrPtr_q + PtrW'(1);
      if (popEff)  rdPtr_d = rdPtr_q + PtrW'(1);
      count_d = count_q + CntW'(pushEff) - CntW'(popEff);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (pushEff && !flush_i) mem_q[wrPtr_q] <= pushData_i;
  end

endmodule

// File: rtl/fetch_queue.sv
// Decoupled fetch stage: one outstanding request to a variable-latency instruction
// memory, responses buffered in a prefetch FIFO consumed by decode with valid/stall.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH  = DefAddrWidth,
  parameter int unsigned           INSTR_WIDTH = DefInstrWidth,
  parameter int unsigned           DEPTH       = 4,
  parameter int unsigned           INSTR_BYTES = DefInstrBytes,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = ADDR_WIDTH'(DefResetPc)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   halt,
  input  logic                   stall,
  input  logic                   jumpDTaken,
  input  logic [ADDR_WIDTH-1:0]  jumpDDest,
  input  logic                   jumpImm,
  input  logic [ADDR_WIDTH-1:0]  jumpImmDest,
  output logic                   memReq,
  output logic [ADDR_WIDTH-1:0]  memAddr,
  input  logic                   memDone,
  input  logic [INSTR_WIDTH-1:0] memData,
  output logic                   instValid,
  output logic [INSTR_WIDTH-1:0] currInstruct,
  output logic [ADDR_WIDTH-1:0]  plusTwoPC,
  output logic                   err
);

  localparam int unsigned           CntW   = $clog2(DEPTH) + 1;
  localparam logic [ADDR_WIDTH-1:0] PcStep = ADDR_WIDTH'(INSTR_BYTES);

  typedef struct packed {
    logic [INSTR_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0]  pcPlus;
  } entry_t;

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] issueAddr_q, issueAddr_d;
  logic                  outstanding_q, outstanding_d;
  logic                  squash_q, squash_d;
  logic                  haltSeen_q, haltSeen_d;
  logic                  err_q, err_d;

  logic                  redirect;
  logic [ADDR_WIDTH-1:0] target;
  logic                  issue;
  logic                  doneValid;
  logic                  push;
  logic                  pop;
  entry_t                pushEntry;
  entry_t                headEntry;
  logic [CntW-1:0]       fifoCount;
  logic                  fifoFull;
  logic                  fifoEmpty;

  assign redirect  = jumpDTaken | jumpImm;
  assign target    = jumpDTaken ? jumpDDest : jumpImmDest;
  assign doneValid = memDone & outstanding_q;

  assign issue = ~haltSeen_q & ~halt & ~redirect & ~outstanding_q & (fifoCount < CntW'(DEPTH));

  // A response arriving alongside a redirect belongs to the old stream and is dropped.
  assign push = doneValid & ~squash_q & ~redirect & ~fifoFull;
  assign pop  = instValid & ~stall & ~redirect;

  assign pushEntry.instr  = memData;
  assign pushEntry.pcPlus = issueAddr_q + PcStep;

  // Reset gates only the output so rst never enters the flop data paths.
  assign memReq  = issue & rst;
  assign memAddr = pc_q;

  assign instValid    = ~fifoEmpty;
  assign currInstruct = instValid ? headEntry.instr : '0;
  assign plusTwoPC    = instValid ? headEntry.pcPlus : '0;
  assign err          = err_q;

  always_comb begin
    pc_d          = pc_q;
    issueAddr_d   = issueAddr_q;
    outstanding_d = outstanding_q;
    squash_d      = squash_q;
    haltSeen_d    = haltSeen_q | halt;
    err_d         = err_q;

    if (redirect) begin
      pc_d = target;
      if (isMisaligned(64'(target), INSTR_BYTES)) err_d = 1'b1;
      // Squash only a request still in flight; one completing now is consumed here.
      if (doneValid) begin
        outstanding_d = 1'b0;
        squash_d      = 1'b0;
      end else if (outstanding_q) begin
        squash_d = 1'b1;
      end
    end else begin
      if (doneValid) begin
        outstanding_d = 1'b0;
        squash_d      = 1'b0;
      end
      if (issue) begin
        pc_d          = pc_q + PcStep;
        issueAddr_d   = pc_q;
        outstanding_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q          <= RESET_PC;
      issueAddr_q   <= '0;
      outstanding_q <= 1'b0;
      squash_q      <= 1'b0;
      haltSeen_q    <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      issueAddr_q   <= issueAddr_d;
      outstanding_q <= outstanding_d;
      squash_q      <= squash_d;
      haltSeen_q    <= haltSeen_d;
      err_q         <= err_d;
    end
  end

  fetch_fifo #(
    .Depth (DEPTH),
    .Width ($bits(entry_t))
  ) u_fifo (
    .clk_i      (clk),
    .rst_ni     (rst),
    .flush_i    (redirect),
    .push_i     (push),
    .pushData_i (pushEntry),
    .pop_i      (pop),
    .popData_o  (headEntry),
    .count_o    (fifoCount),
    .full_o     (fifoFull),
    .empty_o    (fifoEmpty)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: queue-based reference model checked every cycle, a
// variable-latency memory model, directed scenarios with literal expectations, random phase.
module tb_fetch_queue;
  import fetch_pkg::*;

  localparam int AW    = 16;
  localparam int IW    = 16;
  localparam int DEPTH = 4;
  localparam int IB    = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          halt = 1'b0;
  logic          stall = 1'b0;
  logic          jumpDTaken = 1'b0;
  logic [AW-1:0] jumpDDest = '0;
  logic          jumpImm = 1'b0;
  logic [AW-1:0] jumpImmDest = '0;
  logic          memReq;
  logic [AW-1:0] memAddr;
  logic          memDone = 1'b0;
  logic [IW-1:0] memData = '0;
  logic          instValid;
  logic [IW-1:0] currInstruct;
  logic [AW-1:0] plusTwoPC;
  logic          err;

  always #5 clk = ~clk;

  fetch_queue #(
    .ADDR_WIDTH  (AW),
    .INSTR_WIDTH (IW),
    .DEPTH       (DEPTH),
    .INSTR_BYTES (IB),
    .RESET_PC    (16'h0000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .halt         (halt),
    .stall        (stall),
    .jumpDTaken   (jumpDTaken),
    .jumpDDest    (jumpDDest),
    .jumpImm      (jumpImm),
    .jumpImmDest  (jumpImmDest),
    .memReq       (memReq),
    .memAddr      (memAddr),
    .memDone      (memDone),
    .memData      (memData),
    .instValid    (instValid),
    .currInstruct (currInstruct),
    .plusTwoPC    (plusTwoPC),
    .err          (err)
  );

  int nCmp = 0;
  int nBad = 0;

  function automatic logic [IW-1:0] memFn(input logic [AW-1:0] a);
    return a ^ 16'hC3A5;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model state
  fq_entry_t     mq[$];
  logic [AW-1:0] mPc = '0;
  logic [AW-1:0] mIssue = '0;
  bit            mOut = 0, mSquash = 0, mHalt = 0, mErr = 0;

  // Memory model: in-order responses, each no earlier than its due cycle
  typedef struct {
    logic [AW-1:0] addr;
    int            due;
  } memTxn_t;
  memTxn_t       memQ[$];
  int            cyc = 0;
  int            latMin = 1, latMax = 1;
  bit            nxtDone = 0;
  logic [IW-1:0] nxtData = '0;

  always @(posedge clk) begin
    #1;
    memDone = nxtDone;
    memData = nxtData;
  end

  always @(negedge clk) begin : cmpProc
    logic          red;
    logic [AW-1:0] tgt;
    bit            expReq;
    fq_entry_t     e;
    memTxn_t       t;
    if (!rst) begin
      mq.delete();
      mPc = '0; mIssue = '0; mOut = 0; mSquash = 0; mHalt = 0; mErr = 0;
      chk("rstMemReq", memReq, 0);
      chk("rstInstValid", instValid, 0);
      chk("rstCurrInstruct", currInstruct, 0);
      chk("rstPlusTwoPC", plusTwoPC, 0);
      chk("rstErr", err, 0);
    end else begin
      red    = jumpDTaken | jumpImm;
      tgt    = jumpDTaken ? jumpDDest : jumpImmDest;
      expReq = !mHalt && !halt && !red && !mOut && (mq.size() < DEPTH);
      chk("memReq", memReq, expReq);
      if (expReq) chk("memAddr", memAddr, mPc);
      chk("instValid", instValid, mq.size() != 0);
      chk("currInstruct", currInstruct, (mq.size() != 0) ? mq[0].instr : 16'h0);
      chk("plusTwoPC", plusTwoPC, (mq.size() != 0) ? mq[0].pcPlus : 16'h0);
      chk("err", err, mErr);
      if (red) begin
        mq.delete();
        if (memDone && mOut) begin
          mOut = 0;
          mSquash = 0;
        end else if (mOut) begin
          mSquash = 1;
        end
        mPc = tgt;
        if ((tgt % IB) != 0) mErr = 1;
      end else begin
        if (mq.size() != 0 && !stall) void'(mq.pop_front());
        if (memDone && mOut) begin
          mOut = 0;
          if (mSquash) mSquash = 0;
          else begin
            e.instr  = memData;
            e.pcPlus = mIssue + 16'(IB);
            mq.push_back(e);
          end
        end
        if (expReq) begin
          mOut   = 1;
          mIssue = mPc;
          mPc    = mPc + 16'(IB);
        end
      end
      if (halt) mHalt = 1;
      if (mq.size() > DEPTH) begin
        nBad++;
        $display("FAIL modelOverflow: got %0d entries, limit %0d", mq.size(), DEPTH);
      end
    end
    if (memReq) begin
      t.addr = memAddr;
      t.due  = cyc + $urandom_range(latMin, latMax);
      memQ.push_back(t);
    end
    nxtDone = 0;
    nxtData = 16'($urandom);
    if (memQ.size() != 0 && memQ[0].due <= cyc + 1) begin
      t = memQ.pop_front();
      nxtDone = 1;
      nxtData = memFn(t.addr);
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset(input bit clrMem);
    step();
    rst = 0; halt = 0; stall = 0; jumpDTaken = 0; jumpImm = 0;
    if (clrMem) memQ.delete();
    step();
    step();
    rst = 1;
  endtask

  function automatic logic [AW-1:0] randDest();
    logic [AW-1:0] d;
    d = 16'($urandom);
    if ($urandom_range(0, 7) != 0) d[0] = 1'b0;
    return d;
  endfunction

  logic [AW-1:0] iss[3];
  logic [AW-1:0] popPc[2];
  logic [IW-1:0] popIn[2];
  logic [AW-1:0] addr, plus;
  int            nIss, nPop, nReq;
  bit            found, saw8;

  initial begin
    repeat (2) step();
    rst = 1;

    // A: 1-cycle memory, no stall
    latMin = 1; latMax = 1;
    doReset(1);
    nIss = 0; nPop = 0;
    foreach (iss[k]) iss[k] = 16'hFFFF;
    foreach (popPc[k]) begin popPc[k] = 16'hFFFF; popIn[k] = 16'hFFFF; end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (memReq && nIss < 3) begin iss[nIss] = memAddr; nIss++; end
      if (instValid && nPop < 2) begin
        popPc[nPop] = plusTwoPC; popIn[nPop] = currInstruct; nPop++;
      end
    end
    chk("A_issue0", iss[0], 16'h0000);
    chk("A_issue1", iss[1], 16'h0002);
    chk("A_issue2", iss[2], 16'h0004);
    chk("A_head0", popPc[0], 16'h0002);
    chk("A_head1", popPc[1], 16'h0004);
    chk("A_instr0", popIn[0], 16'hC3A5);

    // B: stall fills the FIFO, then drains in order
    doReset(1);
    stall = 1;
    repeat (14) @(negedge clk);
    chk("B_fullNoReq", memReq, 0);
    chk("B_fullValid", instValid, 1);
    chk("B_fullHead", plusTwoPC, 16'h0002);
    step();
    stall = 0;
    saw8 = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("B_drainOrder", plusTwoPC, 32'(2 + 2 * k));
      if (memReq && memAddr == 16'h0008) saw8 = 1;
    end
    chk("B_fetchResumes", saw8, 1);

    // C: immediate jump squashes the in-flight request at 0x0006
    latMin = 3; latMax = 3;
    doReset(1);
    found = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (memReq && memAddr == 16'h0006) begin found = 1; break; end
    end
    chk("C_req6Seen", found, 1);
    step();
    jumpImm = 1; jumpImmDest = 16'h0100;
    step();
    jumpImm = 0;
    addr = 16'hFFFF;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (memReq) begin addr = memAddr; break; end
    end
    chk("C_nextAddr", addr, 16'h0100);
    plus = 16'hFFFF;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (instValid) begin plus = plusTwoPC; addr = currInstruct; break; end
    end
    chk("C_firstHead", plus, 16'h0102);
    chk("C_firstInstr", addr, 16'hC2A5);

    // D: register jump beats immediate jump
    latMin = 1; latMax = 1;
    doReset(1);
    repeat (3) step();
    jumpDTaken = 1; jumpDDest = 16'h0040;
    jumpImm = 1; jumpImmDest = 16'h0080;
    step();
    jumpDTaken = 0; jumpImm = 0;
    @(negedge clk);
    chk("D_flushed", instValid, 0);
    addr = 16'hFFFF;
    for (int i = 0; i < 10; i++) begin
      if (memReq) begin addr = memAddr; break; end
      @(negedge clk);
    end
    chk("D_nextAddr", addr, 16'h0040);

    // E: misaligned target sets sticky err
    step();
    jumpDTaken = 1; jumpDDest = 16'h0041;
    step();
    jumpDTaken = 0;
    @(negedge clk);
    chk("E_errSet", err, 1);
    repeat (5) @(negedge clk);
    chk("E_errSticky", err, 1);
    doReset(1);
    @(negedge clk);
    chk("E_errCleared", err, 0);

    // F: halt during an outstanding request
    latMin = 3; latMax = 3;
    doReset(1);
    @(negedge clk);
    chk("F_firstReq", memReq, 1);
    step();
    halt = 1;
    step();
    halt = 0;
    nReq = 0; plus = 16'hFFFF;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (memReq) nReq++;
      if (instValid && plus == 16'hFFFF) plus = plusTwoPC;
    end
    chk("F_noReqAfterHalt", nReq, 0);
    chk("F_delivered", plus, 16'h0002);

    // G: reset mid-request; the stray response must be ignored
    latMin = 2; latMax = 2;
    doReset(1);
    found = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (memReq && memAddr == 16'h0004) begin found = 1; break; end
    end
    chk("G_req4Seen", found, 1);
    step();
    rst = 0;
    step();
    rst = 1;
    @(negedge clk);
    chk("G_restartReq", memReq, 1);
    chk("G_restartAddr", memAddr, 16'h0000);
    plus = 16'hFFFF; addr = 16'hFFFF;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (instValid) begin plus = plusTwoPC; addr = currInstruct; break; end
    end
    chk("G_firstHead", plus, 16'h0002);
    chk("G_firstInstr", addr, 16'hC3A5);

    // H: randomized traffic
    latMin = 1; latMax = 4;
    doReset(1);
    for (int i = 0; i < 3000; i++) begin
      step();
      if (((i / 500) % 2) == 1) stall = ($urandom_range(0, 3) != 0);
      else stall = ($urandom_range(0, 3) == 0);
      halt        = ($urandom_range(0, 299) == 0);
      jumpDTaken  = ($urandom_range(0, 24) == 0);
      jumpDDest   = randDest();
      jumpImm     = ($urandom_range(0, 19) == 0);
      jumpImmDest = randDest();
      rst         = ($urandom_range(0, 249) != 0);
      if (!rst && $urandom_range(0, 1) == 1) memQ.delete();
    end
    step();
    rst = 1; halt = 0; stall = 0; jumpDTaken = 0; jumpImm = 0;
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
